// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// Covers FSM state encodings, parity type codes and line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for one UART data word.
// Even parity makes the count of 1s over data plus parity even.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: start bit, LSB-first data from the serializer,
// optional parity, then STOP_BITS stop bits. One bit per baud clock.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_err
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int STOP_W = $clog2(STOP_BITS + 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      data_cnt;
    logic [STOP_W-1:0]     stop_cnt;
    logic [DATA_WIDTH-1:0] data_latched;
    logic                  par_en_latched;
    logic                  par_typ_latched;
    logic                  par_bit;
    logic                  last_stop;
    logic                  can_accept;
    logic                  data_timeout;

    assign last_stop    = (state == STOP) && (stop_cnt == STOP_W'(STOP_BITS - 1));
    assign can_accept   = (state == IDLE) || last_stop;
    // DATA_WIDTH data cycles elapsed and the serializer never flagged its last bit.
    assign data_timeout = (state == DATA) && !ser_done &&
                          (data_cnt == CNT_W'(DATA_WIDTH - 1));

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_latched),
        .par_typ (par_typ_latched),
        .par_bit (par_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ser_en) state_next = START;
            START:   state_next = DATA;
            DATA: begin
                if (ser_done) begin
                    state_next = par_en_latched ? PARITY : STOP;
                end else if (data_timeout) begin
                    state_next = STOP;
                end
            end
            PARITY:  state_next = STOP;
            STOP: begin
                if (last_stop) begin
                    state_next = ser_en ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ser_en = Data_Valid & can_accept & !RST;
        busy   = (state != IDLE);
        TX_OUT = STOP_BIT;
        case (state)
            START:   TX_OUT = START_BIT;
            DATA:    TX_OUT = ser_data;
            PARITY:  TX_OUT = par_bit;
            default: TX_OUT = STOP_BIT;
        endcase
    end

    // Counters and the per-frame latches; inputs only matter on the accept cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_cnt        <= '0;
            stop_cnt        <= '0;
            tx_err          <= 1'b0;
            data_latched    <= '0;
            par_en_latched  <= 1'b0;
            par_typ_latched <= 1'b0;
        end else begin
            tx_err   <= data_timeout;
            data_cnt <= (state == DATA) ? data_cnt + CNT_W'(1) : '0;
            stop_cnt <= ((state == STOP) && !last_stop) ? stop_cnt + STOP_W'(1) : '0;
            if (ser_en) begin
                data_latched    <= P_DATA;
                par_en_latched  <= PAR_EN;
                par_typ_latched <= PAR_TYP;
            end
        end
    end

endmodule
